sram_bist_seq: RTL

- March-style SRAM self-test sequencer that sits directly upstream of the 32-bit registered mismatch comparator.
- Drives the SRAM port, then presents read data and latency-aligned expected data to the comparator (d1/d2).
- Consumes the comparator's registered mismatch flag to count errors and capture the first failing address.
- Outputs a pass/fail summary when the test completes.

---
 rtl/bist_pkg.sv | 55 +++++
 rtl/bist_align_pipe.sv | 46 ++++
 rtl/sram_bist_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared types and helpers for the March-style SRAM BIST sequencer.
//   bist_state_t  : sequencer FSM states
//   march_elem_t  : per-state decode of the current march element
//   march_elem()  : state -> element decode (active / write / inverted / descending)
//   exp_data()    : pattern to write or expect in a state (P or ~P)
//   depth()       : SRAM depth for an address width
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_BG,
        ST_RD_UP,
        ST_WR_INV,
        ST_RD_DN,
        ST_DRAIN,
        ST_DONE
    } bist_state_t;

    localparam int ADDR_W_DEF = 8;
    localparam int N_DEF      = 1 << ADDR_W_DEF;
    // Widest data path exp_data() can serve; callers keep the low DATA_W bits.
    localparam int DATA_MAX   = 256;

    typedef struct packed {
        logic act;   // SRAM access issued this cycle
        logic we;    // write (1) or read (0)
        logic inv;   // element uses ~P
        logic down;  // address walks N-1 -> 0
    } march_elem_t;

    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction

    function automatic march_elem_t march_elem(input bist_state_t s);
        march_elem_t m;
        m = '0;
        case (s)
            ST_WR_BG:  m = '{act: 1'b1, we: 1'b1, inv: 1'b0, down: 1'b0};
            ST_RD_UP:  m = '{act: 1'b1, we: 1'b0, inv: 1'b0, down: 1'b0};
            ST_WR_INV: m = '{act: 1'b1, we: 1'b1, inv: 1'b1, down: 1'b0};
            ST_RD_DN:  m = '{act: 1'b1, we: 1'b0, inv: 1'b1, down: 1'b1};
            default:   m = '0;
        endcase
        return m;
    endfunction

    function automatic logic [DATA_MAX-1:0] exp_data(input bist_state_t s,
                                                     input logic [DATA_MAX-1:0] p);
        march_elem_t m;
        m = march_elem(s);
        return m.inv ? ~p : p;
    endfunction

endpackage

// File: rtl/bist_align_pipe.sv
// Delay line carrying {valid, expected data, address} for each issued read so
// it lines up with SRAM read data arriving DEPTH cycles later.
//   clk, rst              : clock, async active-high reset (clears all stages)
//   in_vld/in_data/in_addr: read issued this cycle and its expected data/address
//   out_vld/out_data/out_addr: same, DEPTH cycles later
module bist_align_pipe #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr
);

    logic [DEPTH:1]             vld_pipe;
    logic [DEPTH:1][DATA_W-1:0] data_pipe;
    logic [DEPTH:1][ADDR_W-1:0] addr_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            data_pipe <= '0;
            addr_pipe <= '0;
        end else begin
            vld_pipe[1]  <= in_vld;
            data_pipe[1] <= in_data;
            addr_pipe[1] <= in_addr;
            for (int i = 2; i <= DEPTH; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                data_pipe[i] <= data_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
        end
    end

    assign out_vld  = vld_pipe[DEPTH];
    assign out_data = data_pipe[DEPTH];
    assign out_addr = addr_pipe[DEPTH];

endmodule

// File: rtl/sram_bist_seq.sv
// March SRAM self-test sequencer: {w P up, r P up, w ~P up, r ~P down}.
// Drives the SRAM port, feeds read data and aligned expected data to a
// registered mismatch comparator, and accounts its result into a saturating
// error count plus first-failing address.
//   start_i/data_bg_i : start pulse (IDLE only) and background pattern P
//   busy_o/done_o/pass_o : run status, one-cycle done pulse, zero-error verdict
//   err_cnt_o/fail_addr_o : mismatch count and first failing address
//   sram_*            : SRAM port, decoded from registered state/address
//   cmp_rdata_o/cmp_exp_o/cmp_result_i : comparator d1, d2 and registered flag
module sram_bist_seq
    import bist_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1,
    parameter int ERR_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_bg_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [ERR_W-1:0]  err_cnt_o,
    output logic [ADDR_W-1:0] fail_addr_o,
    output logic              sram_cs_o,
    output logic              sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    input  logic [DATA_W-1:0] sram_rdata_i,
    output logic [DATA_W-1:0] cmp_rdata_o,
    output logic [DATA_W-1:0] cmp_exp_o,
    input  logic              cmp_result_i
);

    localparam int              N     = depth(ADDR_W);
    localparam logic [ADDR_W-1:0] A_MAX = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] A_DRN = ADDR_W'(RD_LAT);

    bist_state_t       state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;   // doubles as drain counter in DRAIN
    logic [DATA_W-1:0] pat;
    logic [ERR_W-1:0]  err_cnt;
    logic [ADDR_W-1:0] fail_addr;
    logic              fail_seen;
    logic              pass_q;
    logic              dly_vld;
    logic [ADDR_W-1:0] dly_addr;

    march_elem_t       me;
    logic [DATA_MAX-1:0] exp_w;
    logic [DATA_W-1:0] elem_data;
    logic              unused_exp;
    logic              rd_issue;
    logic              accept;
    logic              hit;

    logic              p_vld;
    logic [DATA_W-1:0] p_data;
    logic [ADDR_W-1:0] p_addr;

    assign me         = march_elem(state);
    assign exp_w      = exp_data(state, DATA_MAX'(pat));
    assign elem_data  = exp_w[DATA_W-1:0];
    assign unused_exp = ^exp_w[DATA_MAX-1:DATA_W];
    assign rd_issue   = me.act & ~me.we;
    assign accept     = (state == ST_IDLE) & start_i;
    assign hit        = dly_vld & cmp_result_i;

    assign sram_cs_o    = me.act;
    assign sram_we_o    = me.act & me.we;
    assign sram_addr_o  = me.act ? addr : '0;
    assign sram_wdata_o = (me.act & me.we) ? elem_data : '0;

    bist_align_pipe #(
        .DEPTH  (RD_LAT),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_align (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (rd_issue),
        .in_data  (elem_data),
        .in_addr  (addr),
        .out_vld  (p_vld),
        .out_data (p_data),
        .out_addr (p_addr)
    );

    // With no read in flight, d2 mirrors d1 so the comparator sees equality.
    assign cmp_rdata_o = sram_rdata_i;
    assign cmp_exp_o   = p_vld ? p_data : sram_rdata_i;

    assign busy_o      = (state != ST_IDLE) && (state != ST_DONE);
    assign done_o      = (state == ST_DONE);
    assign pass_o      = done_o ? (err_cnt == '0) : pass_q;
    assign err_cnt_o   = err_cnt;
    assign fail_addr_o = fail_addr;

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        case (state)
            ST_IDLE: if (start_i) begin
                state_nxt = ST_WR_BG;
                addr_nxt  = '0;
            end
            ST_WR_BG, ST_RD_UP: begin
                addr_nxt = addr + 1'b1;
                if (addr == A_MAX) begin
                    state_nxt = (state == ST_WR_BG) ? ST_RD_UP : ST_WR_INV;
                    addr_nxt  = '0;
                end
            end
            ST_WR_INV: begin
                addr_nxt = addr + 1'b1;
                if (addr == A_MAX) begin
                    state_nxt = ST_RD_DN;
                    addr_nxt  = A_MAX;
                end
            end
            ST_RD_DN: begin
                addr_nxt = addr - 1'b1;
                if (addr == '0) begin
                    state_nxt = ST_DRAIN;
                    addr_nxt  = '0;
                end
            end
            // RD_LAT+1 cycles: read data latency plus the comparator register.
            ST_DRAIN: begin
                addr_nxt = addr + 1'b1;
                if (addr == A_DRN) begin
                    state_nxt = ST_DONE;
                    addr_nxt  = '0;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: begin
                state_nxt = ST_IDLE;
                addr_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            pat       <= '0;
            err_cnt   <= '0;
            fail_addr <= '0;
            fail_seen <= 1'b0;
            pass_q    <= 1'b0;
            dly_vld   <= 1'b0;
            dly_addr  <= '0;
        end else begin
            state    <= state_nxt;
            addr     <= addr_nxt;
            dly_vld  <= p_vld;
            dly_addr <= p_addr;
            if (accept) begin
                pat       <= data_bg_i;
                err_cnt   <= '0;
                fail_addr <= '0;
                fail_seen <= 1'b0;
                pass_q    <= 1'b0;
            end else begin
                if (hit && (err_cnt != '1))
                    err_cnt <= err_cnt + 1'b1;
                if (hit && !fail_seen) begin
                    fail_seen <= 1'b1;
                    fail_addr <= dly_addr;
                end
                if (state == ST_DONE)
                    pass_q <= (err_cnt == '0);
            end
        end
    end

endmodule
